maq_estados_mascota_param: RTL and testbench



---
 rtl/mascota_pkg.sv | 22 ++
 rtl/divisor_tick.sv | 41 ++++
 rtl/maq_estados_mascota_param.sv | 210 +++++++++++++++++++++
 tb/tb_maq_estados_mascota_param.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mascota_pkg.sv
// Shared definitions for the virtual-pet state machine: state encodings,
// default thresholds and the packed-level slice helper.
package mascota_pkg;

  typedef enum logic [2:0] {
    FELIZ      = 3'd0,
    NEUTRO     = 3'd1,
    NECESITADO = 3'd2,
    CRITICO    = 3'd3,
    MUERTO     = 3'd4,
    DORMIDO    = 3'd5
  } estado_e;

  localparam int unsigned DEF_MAX_LEVEL = 5;
  localparam int unsigned DEF_LOW_TH    = 2;

  // LSB position of need idx inside the packed niveles bus.
  function automatic int unsigned nivel_lsb(input int unsigned idx, input int unsigned level_w);
    return idx * level_w;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Tick prescaler: counts 0..DIV-1 with the divide chosen at run time
// (DIV_A when sel_b=0, DIV_B when sel_b=1) and a synchronous clear.
module divisor_tick
  import mascota_pkg::*;
#(
  parameter int unsigned DIV_A = 50_000_000,
  parameter int unsigned DIV_B = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic sel_b,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int unsigned CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(DIV_A - 1);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(DIV_B - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;

  always_comb begin
    last  = sel_b ? LAST_B : LAST_A;
    tick  = (cnt_q == last);
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/maq_estados_mascota_param.sv
// Virtual-pet need tracker and state machine with long-press test mode.
// Optional auto-sleep (DORMIDO) is built only when MASCOTA_AUTOSLEEP_EN is defined.
//
// state      | meaning
// FELIZ      | every need at MAX_LEVEL-1 or above
// NEUTRO     | no need low, not all high
// NECESITADO | some need at or below LOW_TH
// CRITICO    | some need empty; death timer running
// MUERTO     | sticky until reset; levels frozen
// DORMIDO    | idle sleep, slower decay (auto-sleep builds only)
module maq_estados_mascota_param
  import mascota_pkg::*;
#(
  parameter int unsigned N_NEEDS     = 4,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int unsigned LOW_TH      = DEF_LOW_TH,
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned TEST_DIV    = 10,
  parameter int unsigned DECAY_TICKS = 5,
  parameter int unsigned CRIT_TICKS  = 10,
  parameter int unsigned HOLD_CYCLES = 250_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_NEEDS-1:0]           btn,
  input  logic                         btn_test,
  output logic [N_NEEDS*LEVEL_W-1:0]   niveles,
  output logic [2:0]                   estado,
  output logic                         modo_test,
  output logic                         tick
);

  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LVL_LOW  = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] LVL_HIGH = LEVEL_W'(MAX_LEVEL - 1);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam int unsigned DEC_W = $clog2(2 * DECAY_TICKS + 1);
  localparam logic [DEC_W-1:0] DEC_LAST       = DEC_W'(DECAY_TICKS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST_SLEEP = DEC_W'(2 * DECAY_TICKS - 1);

  localparam int unsigned CRIT_W = $clog2(CRIT_TICKS + 1);
  localparam logic [CRIT_W-1:0] CRIT_LAST = CRIT_W'(CRIT_TICKS - 1);

  estado_e              estado_q, estado_d, derivado;
  logic [N_NEEDS-1:0]   btn_prev_q, btn_prev_d;
  logic [N_NEEDS-1:0]   btn_edge, inc;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 modo_test_q, modo_test_d;
  logic                 test_toggle;
  logic [DEC_W-1:0]     dec_q, dec_d, dec_last;
  logic                 decay;
  logic [CRIT_W-1:0]    crit_q, crit_d;
  logic                 muerto, dormido;
  logic [N_NEEDS-1:0]   lvl_zero, lvl_low, lvl_high;

`ifdef MASCOTA_AUTOSLEEP_EN
  localparam int unsigned IDLE_W = $clog2(4 * DECAY_TICKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(4 * DECAY_TICKS - 1);
  logic [IDLE_W-1:0]    idle_q, idle_d;
`endif

  divisor_tick #(
    .DIV_A (TICK_DIV),
    .DIV_B (TEST_DIV)
  ) u_divisor_tick (
    .clk   (clk),
    .reset (reset),
    .sel_b (modo_test_q),
    .clr   (test_toggle),
    .tick  (tick)
  );

  // Test-mode long press: hold counter saturates so one press toggles once.
  always_comb begin
    btn_prev_d  = btn;
    btn_edge    = btn & ~btn_prev_q;
    hold_d      = hold_q;
    test_toggle = 1'b0;
    if (!btn_test) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
      if (hold_q == HOLD_LAST) begin
        test_toggle = 1'b1;
      end
    end
    modo_test_d = modo_test_q ^ test_toggle;
  end

  // Decay timer; in DORMIDO every edge wakes the pet instead of feeding it.
  always_comb begin
    muerto   = (estado_q == MUERTO);
    dormido  = (estado_q == DORMIDO);
    dec_last = dormido ? DEC_LAST_SLEEP : DEC_LAST;
    dec_d    = dec_q;
    decay    = 1'b0;
    if (tick && !muerto) begin
      if (dec_q >= dec_last) begin
        dec_d = '0;
        decay = 1'b1;
      end else begin
        dec_d = dec_q + DEC_W'(1);
      end
    end
    inc = (muerto || dormido) ? '0 : btn_edge;
  end

  for (genvar i = 0; i < N_NEEDS; i++) begin : g_need
    logic [LEVEL_W-1:0] lvl_q, lvl_d;

    always_comb begin
      lvl_d = lvl_q;
      if (inc[i] && !decay) begin
        if (lvl_q != LVL_MAX) lvl_d = lvl_q + LEVEL_W'(1);
      end else if (decay && !inc[i]) begin
        if (lvl_q != '0) lvl_d = lvl_q - LEVEL_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lvl_q <= LVL_MAX;
      end else begin
        lvl_q <= lvl_d;
      end
    end

    assign niveles[nivel_lsb(i, LEVEL_W) +: LEVEL_W] = lvl_q;
    assign lvl_zero[i] = (lvl_q == '0);
    assign lvl_low[i]  = (lvl_q <= LVL_LOW);
    assign lvl_high[i] = (lvl_q >= LVL_HIGH);
  end

  always_comb begin
    if (|lvl_zero)      derivado = CRITICO;
    else if (|lvl_low)  derivado = NECESITADO;
    else if (&lvl_high) derivado = FELIZ;
    else                derivado = NEUTRO;

    estado_d = derivado;
    crit_d   = '0;
`ifdef MASCOTA_AUTOSLEEP_EN
    idle_d   = '0;
`endif
    if (muerto) begin
      estado_d = MUERTO;
    end else begin
      if (estado_q == CRITICO) begin
        crit_d = crit_q;
        if (tick) begin
          crit_d = crit_q + CRIT_W'(1);
          if (crit_q == CRIT_LAST) estado_d = MUERTO;
        end
      end
`ifdef MASCOTA_AUTOSLEEP_EN
      if (dormido) begin
        // Stay asleep unless woken by an edge or starved to zero.
        if (!(|lvl_zero) && !(|btn_edge)) estado_d = DORMIDO;
      end else if ((estado_q == FELIZ || estado_q == NEUTRO) && !(|btn_edge)) begin
        idle_d = idle_q;
        if (tick) begin
          if (idle_q == IDLE_LAST) begin
            idle_d = '0;
            if (derivado == FELIZ || derivado == NEUTRO) estado_d = DORMIDO;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= FELIZ;
      btn_prev_q  <= '0;
      hold_q      <= '0;
      modo_test_q <= 1'b0;
      dec_q       <= '0;
      crit_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      btn_prev_q  <= btn_prev_d;
      hold_q      <= hold_d;
      modo_test_q <= modo_test_d;
      dec_q       <= dec_d;
      crit_q      <= crit_d;
    end
  end

`ifdef MASCOTA_AUTOSLEEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign estado    = estado_q;
  assign modo_test = modo_test_q;

endmodule

// File: tb/tb_maq_estados_mascota_param.sv
// Directed bench for maq_estados_mascota_param with shortened dividers.
module tb_maq_estados_mascota_param;

  logic        clk;
  logic        reset;
  logic [3:0]  btn;
  logic        btn_test;
  logic [11:0] niveles;
  logic [2:0]  estado;
  logic        modo_test;
  logic        tick;

  int checks   = 0;
  int failures = 0;

  maq_estados_mascota_param #(
    .N_NEEDS     (4),
    .LEVEL_W     (3),
    .MAX_LEVEL   (5),
    .LOW_TH      (2),
    .TICK_DIV    (4),
    .TEST_DIV    (2),
    .DECAY_TICKS (2),
    .CRIT_TICKS  (3),
    .HOLD_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .btn_test  (btn_test),
    .niveles   (niveles),
    .estado    (estado),
    .modo_test (modo_test),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    btn      = '0;
    btn_test = 1'b0;
    cyc(2);
    chk("rst_niveles", 32'(niveles), 32'h0B6D);
    chk("rst_estado",  32'(estado), 32'd0);
    chk("rst_modo",    32'(modo_test), 32'd0);
    chk("rst_tick",    32'(tick), 32'd0);

    // Scenario A: no buttons, starve to death
    reset = 1'b0;
    cyc(1); chk("tick_e1", 32'(tick), 32'd0);
    cyc(2); chk("tick_e3", 32'(tick), 32'd1);
    cyc(1); chk("tick_e4", 32'(tick), 32'd0);
    cyc(3); chk("tick_e7", 32'(tick), 32'd1);
    cyc(1); chk("decay1_niveles", 32'(niveles), 32'h0924);
    cyc(1); chk("decay1_estado", 32'(estado), 32'd0);
    cyc(8); chk("decay2_niveles", 32'(niveles), 32'h06DB);
            chk("decay2_estado", 32'(estado), 32'd1);
    cyc(15); chk("decay4_niveles", 32'(niveles), 32'h0249);
    cyc(1);  chk("decay4_estado", 32'(estado), 32'd2);
    cyc(7);  chk("decay5_niveles", 32'(niveles), 32'h0000);
    cyc(1);  chk("critico_estado", 32'(estado), 32'd3);
    cyc(10); chk("critico_hold", 32'(estado), 32'd3);
    cyc(1);  chk("muerto_estado", 32'(estado), 32'd4);
    btn = 4'hF;
    cyc(1);
    btn = 4'h0;
    cyc(2);
    chk("muerto_frozen", 32'(niveles), 32'h0000);
    chk("muerto_sticky", 32'(estado), 32'd4);
    chk("muerto_tick",   32'(tick), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_niveles", 32'(niveles), 32'h0B6D);
    chk("async_rst_estado",  32'(estado), 32'd0);
    cyc(2);

    // Scenario B: button saturation and coincidence with decay
    reset = 1'b0;
    cyc(1);
    btn = 4'b0100;
    cyc(1); chk("btn_sat", 32'(niveles), 32'h0B6D);
    btn = 4'b0000;
    cyc(21);
    btn = 4'b0100;
    cyc(1); chk("btn_vs_decay", 32'(niveles), 32'h04D2);
    btn = 4'b0000;
    cyc(1);
    btn = 4'b0011;
    cyc(1); chk("btn_multi", 32'(niveles), 32'h04DB);
    cyc(2); chk("btn_held", 32'(niveles), 32'h04DB);
            chk("btn_estado", 32'(estado), 32'd2);
    btn = 4'b0000;
    #2 reset = 1'b1;
    cyc(2);

    // Scenario C: long-press test mode
    reset    = 1'b0;
    btn_test = 1'b1;
    cyc(7); chk("hold7_modo", 32'(modo_test), 32'd0);
    cyc(1); chk("hold8_modo", 32'(modo_test), 32'd1);
    cyc(1); chk("fast_tick_hi", 32'(tick), 32'd1);
    cyc(1); chk("fast_tick_lo", 32'(tick), 32'd0);
    cyc(20); chk("no_retoggle", 32'(modo_test), 32'd1);
    btn_test = 1'b0;
    cyc(2);
    btn_test = 1'b1;
    cyc(7); chk("rehold7_modo", 32'(modo_test), 32'd1);
    cyc(1); chk("rehold8_modo", 32'(modo_test), 32'd0);
    btn_test = 1'b0;
    cyc(2); chk("slow_tick_lo", 32'(tick), 32'd0);
    cyc(1); chk("slow_tick_hi", 32'(tick), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
